// File: rtl/pp_loop_mon_pkg.sv
// Shared types and constants for the pipelined-loop progress monitor.
package pp_loop_mon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } loop_state_e;

  localparam int unsigned ERR_UNDER   = 0;
  localparam int unsigned ERR_OVER    = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

endpackage

// File: rtl/pp_sat_cnt.sv
// Saturating up-counter with synchronous clear and a freeze that overrides everything.
module pp_sat_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             freeze,
  output logic [WIDTH-1:0] count
);

  // Hold at all-ones instead of wrapping; clear wins over increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!freeze) begin
      if (clr) begin
        count <= '0;
      end else if (inc && (count != '1)) begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pp_loop_monitor.sv
// Turns the per-cycle control snapshot of one pipelined loop into loop-level
// progress state: iteration counts, in-flight depth, stalls, trip count and
// sticky protocol/deadlock errors.
module pp_loop_monitor
  import pp_loop_mon_pkg::*;
#(
  parameter int unsigned FSM_WIDTH   = 2,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned DEPTH_MAX   = 8,
  parameter int unsigned STALL_LIMIT = 100000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [FSM_WIDTH-1:0]               cur_state,
  input  logic [FSM_WIDTH-1:0]               pre_loop_state0,
  input  logic [FSM_WIDTH-1:0]               loop_quit_state,
  input  logic [FSM_WIDTH-1:0]               iter_start_state,
  input  logic [FSM_WIDTH-1:0]               iter_end_state,
  input  logic [FSM_WIDTH-1:0]               post_loop_state0,
  input  logic [FSM_WIDTH-1:0]               post_loop_state1,
  input  logic [FSM_WIDTH-1:0]               post_loop_state2,
  input  logic [FSM_WIDTH-1:0]               post_loop_state3,
  input  logic [FSM_WIDTH-1:0]               post_loop_state4,
  input  logic [FSM_WIDTH-1:0]               post_loop_state5,
  input  logic [FSM_WIDTH-1:0]               post_loop_state6,
  input  logic [FSM_WIDTH-1:0]               post_loop_state7,
  input  logic                               pre_states_valid,
  input  logic [7:0]                         post_states_valid,
  input  logic                               iter_start_enable,
  input  logic                               iter_start_block,
  input  logic                               iter_end_enable,
  input  logic                               iter_end_block,
  input  logic                               quit_at_end,
  input  logic                               finish,
  output logic [2:0]                         loop_state,
  output logic [CNT_WIDTH-1:0]               iter_started,
  output logic [CNT_WIDTH-1:0]               iter_ended,
  output logic [CNT_WIDTH-1:0]               stall_cycles,
  output logic [CNT_WIDTH-1:0]               trip_count,
  output logic [$clog2(DEPTH_MAX+1)-1:0]     inflight,
  output logic [$clog2(DEPTH_MAX+1)-1:0]     max_inflight,
  output logic                               loop_done,
  output logic [2:0]                         err
);

  localparam int unsigned IW = $clog2(DEPTH_MAX + 1);

  loop_state_e          state_q, state_nx;
  logic                 frozen_q, freeze;
  logic [IW-1:0]        inflight_q, inflight_nx, max_q;
  logic [2:0]           err_q, err_nx;
  logic [CNT_WIDTH-1:0] trip_q, ended_nx, idle_cnt;
  logic                 done_q;

  logic                 start_evt, end_evt, stall, post_hit;
  logic                 in_run, active, s_ok, e_ok, under, over, drain_start;
  logic                 inc_start, inc_end, idle_evt, timeout, idle_clr;
  logic [FSM_WIDTH-1:0] post_state [8];

  assign post_state[0] = post_loop_state0;
  assign post_state[1] = post_loop_state1;
  assign post_state[2] = post_loop_state2;
  assign post_state[3] = post_loop_state3;
  assign post_state[4] = post_loop_state4;
  assign post_state[5] = post_loop_state5;
  assign post_state[6] = post_loop_state6;
  assign post_state[7] = post_loop_state7;

  // Decode the snapshot into events and compute every next-state value.
  // Illegal starts/ends (underflow, overflow, start while draining) only raise
  // errors; they are not counted as iterations.
  always_comb begin
    start_evt   = iter_start_enable & ~iter_start_block & (cur_state == iter_start_state);
    end_evt     = iter_end_enable & ~iter_end_block & (cur_state == iter_end_state);
    stall       = (iter_start_enable & iter_start_block) | (iter_end_enable & iter_end_block);
    post_hit    = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      post_hit = post_hit | (post_states_valid[i] & (cur_state == post_state[i]));
    end
    freeze      = finish | frozen_q;
    in_run      = (state_q == RUN) || (state_q == DRAIN);
    active      = (state_q != DONE);
    s_ok        = active && (state_q != DRAIN) && start_evt;
    e_ok        = active && end_evt;
    drain_start = (state_q == DRAIN) && start_evt;
    under       = e_ok && !s_ok && (inflight_q == '0);
    over        = s_ok && !e_ok && (inflight_q == IW'(DEPTH_MAX));
    inc_start   = s_ok && !over;
    inc_end     = e_ok && !under;
    inflight_nx = inflight_q;
    if (inc_start && !inc_end) inflight_nx = inflight_q + IW'(1);
    if (inc_end && !inc_start) inflight_nx = inflight_q - IW'(1);
    ended_nx    = (inc_end && (iter_ended != '1)) ? iter_ended + CNT_WIDTH'(1) : iter_ended;
    idle_evt    = in_run && !(start_evt || end_evt);
    timeout     = idle_evt && (idle_cnt >= CNT_WIDTH'(STALL_LIMIT - 1));
    idle_clr    = start_evt || end_evt || !in_run;

    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (s_ok) state_nx = RUN;
        else if (pre_states_valid && (cur_state == pre_loop_state0)) state_nx = ARMED;
      end
      ARMED: if (s_ok) state_nx = RUN;
      RUN: if ((cur_state == loop_quit_state) && (quit_at_end ? end_evt : 1'b1)) state_nx = DRAIN;
      DRAIN: if ((inflight_nx == '0) && post_hit) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (timeout) state_nx = IDLE;

    err_nx = err_q;
    err_nx[ERR_UNDER]   = err_q[ERR_UNDER] | under;
    err_nx[ERR_OVER]    = err_q[ERR_OVER] | over | drain_start;
    err_nx[ERR_TIMEOUT] = err_q[ERR_TIMEOUT] | timeout;
  end

  pp_sat_cnt #(.WIDTH(CNT_WIDTH)) u_started (
    .clock(clock), .reset(reset), .inc(inc_start), .clr(state_q == DONE),
    .freeze(freeze), .count(iter_started)
  );

  pp_sat_cnt #(.WIDTH(CNT_WIDTH)) u_ended (
    .clock(clock), .reset(reset), .inc(inc_end), .clr(state_q == DONE),
    .freeze(freeze), .count(iter_ended)
  );

  pp_sat_cnt #(.WIDTH(CNT_WIDTH)) u_stall (
    .clock(clock), .reset(reset), .inc(stall && in_run), .clr(1'b0),
    .freeze(freeze), .count(stall_cycles)
  );

  pp_sat_cnt #(.WIDTH(CNT_WIDTH)) u_idle (
    .clock(clock), .reset(reset), .inc(idle_evt), .clr(idle_clr),
    .freeze(freeze), .count(idle_cnt)
  );

  // Loop FSM plus registered depth, error, trip-count and done state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      frozen_q   <= 1'b0;
      inflight_q <= '0;
      max_q      <= '0;
      err_q      <= '0;
      trip_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      if (finish) frozen_q <= 1'b1;
      if (freeze) begin
        done_q <= 1'b0;
      end else begin
        state_q    <= state_nx;
        inflight_q <= (state_q == DONE) ? '0 : inflight_nx;
        if (inflight_nx > max_q) max_q <= inflight_nx;
        err_q      <= err_nx;
        done_q     <= (state_nx == DONE);
        if ((state_nx == DONE) && (state_q != DONE)) trip_q <= ended_nx;
      end
    end
  end

  assign loop_state   = state_q;
  assign inflight     = inflight_q;
  assign max_inflight = max_q;
  assign err          = err_q;
  assign trip_count   = trip_q;
  assign loop_done    = done_q;

endmodule

// File: doc/pp_loop_monitor.md
# pp_loop_monitor

Consumes the per-cycle control snapshot of one pipelined loop (FSM state, pre/post/quit states, iteration start/end enables and blocks, finish) and turns it into loop-level progress state. Tracks iterations started, completed and in flight, stall cycles and trip count, and raises sticky protocol/deadlock errors. It sits directly downstream of the pipelined-loop interface in the co-simulation bench, one instance per pipelined loop.

## Interface
- FSM_WIDTH, 2, width of the FSM state encodings
- CNT_WIDTH, 32, width of all event/cycle counters
- DEPTH_MAX, 8, maximum legal iterations in flight (pipeline depth)
- STALL_LIMIT, 100000, idle cycles in RUN/DRAIN before timeout
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cur_state, pre_loop_state0, loop_quit_state, iter_start_state, iter_end_state  in  FSM_WIDTH each  state encodings
- post_loop_state0..7  in  FSM_WIDTH each  post-loop states
- pre_states_valid  in  1;  post_states_valid  in  8  validity per post state
- iter_start_enable, iter_start_block, iter_end_enable, iter_end_block, quit_at_end, finish  in  1 each
- loop_state  out  3  current monitor state (package enum)
- iter_started, iter_ended, stall_cycles, trip_count  out  CNT_WIDTH each
- inflight, max_inflight  out  $clog2(DEPTH_MAX+1)
- loop_done  out  1  one-cycle pulse at loop completion
- err  out  3  sticky: [0] underflow, [1] overflow, [2] timeout

## Operation
- start_evt = iter_start_enable & ~iter_start_block & (cur_state==iter_start_state); end_evt likewise with iter_end_*.
- stall = (iter_start_enable & iter_start_block) | (iter_end_enable & iter_end_block).
- post_hit = OR over i of post_states_valid[i] & (cur_state==post_loop_state_i).
- States: IDLE, ARMED, RUN, DRAIN, DONE.
  - IDLE -> ARMED: pre_states_valid & cur_state==pre_loop_state0.
  - IDLE/ARMED -> RUN: start_evt (counted in that cycle).
  - RUN -> DRAIN: cur_state==loop_quit_state and (quit_at_end ? end_evt : 1).
  - DRAIN -> DONE: inflight==0 after this cycle's updates and post_hit.
  - DONE -> IDLE unconditionally next cycle; loop_done=1 only in DONE.
  - any -> IDLE on timeout (err[2] set).
- inflight: +1 on start_evt only, -1 on end_evt only, unchanged on both. max_inflight tracks peak.
- end_evt with inflight==0 and no start_evt: err[0] set, inflight held at 0. start_evt with inflight==DEPTH_MAX and no end_evt: err[1] set, inflight held.
- start_evt in DRAIN: err[1] set, not counted.
- Counters saturate at all-ones, never wrap. stall_cycles counts only in RUN/DRAIN.
- trip_count: latched from iter_ended on entry to DONE; iter_started/iter_ended/inflight cleared on DONE->IDLE; stall_cycles, max_inflight, err persist until reset.
- finish=1: all state and counters freeze (sticky) until reset; loop_done suppressed.

## Timing
- All outputs registered; reset value of every output 0, loop_state=IDLE.
- Events sampled on cycle N appear on outputs at cycle N+1.
- Timeout: idle counter reset on start_evt|end_evt and on RUN entry; err[2] asserts the cycle after STALL_LIMIT consecutive event-free cycles in RUN/DRAIN.
- Reset mid-loop: immediate return to IDLE, all outputs 0 without waiting for clock.

## Structure
- Package pp_loop_mon_pkg: loop state enum (IDLE=0, ARMED=1, RUN=2, DRAIN=3, DONE=4), err bit index constants ERR_UNDER=0, ERR_OVER=1, ERR_TIMEOUT=2.
- Sub-module pp_sat_cnt (parameterised width, inc/clr/freeze, saturating) instantiated for iter_started, iter_ended, stall_cycles, idle counter.

## Test plan
- Pre state, then 10 starts one per cycle, ends trailing by 3, quit on 10th end with quit_at_end=1, post_hit -> max_inflight=3, trip_count=10, loop_done pulse exactly once, err=0.
- Start and end every cycle for 20 cycles with inflight=2 -> inflight stays 2, iter_started=iter_ended+2.
- iter_end_enable=1, iter_end_block=1 for 5 cycles in RUN -> stall_cycles=5, inflight unchanged.
- end_evt with inflight=0 -> err=3'b001, inflight=0; 9 starts with DEPTH_MAX=8 -> err[1]=1, inflight=8.
- STALL_LIMIT=16, no events in RUN for 16 cycles -> err[2]=1, loop_state=IDLE; reset asserted mid-RUN -> all outputs 0 asynchronously.
